// File: rtl/booth_final_adder.sv
// Final carry-propagate adder for the radix-16 Booth multiplier.
// Two-stage valid/ready pipe; the add is split at the half-word boundary.
module booth_final_adder #(
  parameter int LENGTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LENGTH*2-1:0]   C,
  input  logic [LENGTH*2-1:0]   D,
  input  logic                  Co,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LENGTH*2-1:0]   P,
  output logic                  ovf
);

  localparam int L = LENGTH;
  localparam int W = LENGTH*2;

  typedef struct packed {
    logic [L:0]   lo;
    logic [L-1:0] dhi;
    logic [L-1:0] ahi;
    logic         xtra;
  } s1_t;

  typedef struct packed {
    logic [W-1:0] p;
    logic         ovf;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;

  logic [W-1:0] a;
  logic         accept;
  logic         s2_load;
  logic         consume;
  logic [L:0]   hi_sum;

  // C bit i carries weight 2^(i+1); its top bit falls off the product.
  assign a = {C[W-2:0], 1'b0};

  assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = !s1_v_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign consume  = s2_v_q && out_ready;

  assign hi_sum = {1'b0, s1_q.dhi}
                + {1'b0, s1_q.ahi}
                + {{L{1'b0}}, s1_q.lo[L]};

  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;

    if (accept) begin
      s1_d.lo   = {1'b0, D[L-1:0]} + {1'b0, a[L-1:0]};
      s1_d.dhi  = D[W-1:L];
      s1_d.ahi  = a[W-1:L];
      s1_d.xtra = C[W-1] | Co;
      s1_v_d    = 1'b1;
    end else if (s2_load) begin
      s1_v_d    = 1'b0;
    end

    if (s2_load) begin
      s2_d.p   = {hi_sum[L-1:0], s1_q.lo[L-1:0]};
      s2_d.ovf = hi_sum[L] | s1_q.xtra;
      s2_v_d   = 1'b1;
    end else if (consume) begin
      s2_v_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  assign out_valid = s2_v_q;
  assign P         = s2_q.p;
  assign ovf       = s2_q.ovf;

endmodule

// File: tb/tb_booth_final_adder.sv
// Scoreboard bench for booth_final_adder (LENGTH=32).
// Inputs change on the falling edge; handshakes observed 1 time unit later.
module tb_booth_final_adder;

  localparam int L = 32;
  localparam int W = 64;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         Co        = 1'b0;
  logic [W-1:0] C         = '0;
  logic [W-1:0] D         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         ovf;
  logic [W-1:0] P;

  booth_final_adder #(.LENGTH(L)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .D         (D),
    .Co        (Co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [W-1:0] p;
    logic         o;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_p = '0;
  logic         hold_o = 1'b0;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Integer sum D + 2*C + Co*2^64; ovf is anything at or above 2^64.
  function automatic exp_t model(input logic [W-1:0] c,
                                 input logic [W-1:0] d,
                                 input logic co);
    logic [W+1:0] s;
    exp_t e;
    s = {2'b00, d} + ({2'b00, c} << 1) + ({{(W+1){1'b0}}, co} << W);
    e.p = s[W-1:0];
    e.o = |s[W+1:W];
    return e;
  endfunction

  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (hold_v) begin
      chk("stall_P", P, hold_p);
      chk("stall_ovf", 64'(ovf), 64'(hold_o));
      chk("stall_valid", 64'(out_valid), 64'(1));
    end
    if (acc) sb.push_back(model(C, D, Co));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("P", P, e.p);
        chk("ovf", 64'(ovf), 64'(e.o));
      end
    end
    hold_v = out_valid && !out_ready;
    hold_p = P;
    hold_o = ovf;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic single(input logic [W-1:0] c, input logic [W-1:0] d,
                        input logic co, input logic [W-1:0] ep,
                        input logic eo, input string tag);
    bit a;
    C = c; D = d; Co = co;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick(a);
    chk({tag, "_acc"}, 64'(a), 64'(1));
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
    tick(a);
    chk({tag, "_lat2"}, 64'(out_valid), 64'(1));
    chk({tag, "_P"}, P, ep);
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick(a);
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(a);
  endtask

  initial begin
    bit a;
    bit pend;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_P", P, 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    single(64'h0000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0,
           64'h0000_0001_0000_0001, 1'b0, "halfcy");
    single(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'h0000_0000_0000_0001, 1'b1, "wrap");
    single(64'h8000_0000_0000_0000, 64'h0, 1'b0,
           64'h0, 1'b1, "ctop");
    single(64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           64'h1234_5678_9ABC_DEF0, 1'b1, "co");
    drain();

    // Backpressure: two accepts fill the pipe, third waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    C = 64'h11; D = 64'h100;
    tick(a); chk("bp_acc0", 64'(a), 64'(1));
    C = 64'h22; D = 64'h200;
    tick(a); chk("bp_acc1", 64'(a), 64'(1));
    C = 64'h33; D = 64'h300;
    tick(a); chk("bp_acc2_blk", 64'(a), 64'(0));
    tick(a); chk("bp_acc2_blk2", 64'(a), 64'(0));
    out_ready = 1'b1;
    tick(a); chk("bp_acc2_same", 64'(a), 64'(1));
    in_valid = 1'b0;
    chk("bp_nogap1", 64'(out_valid), 64'(1));
    tick(a);
    chk("bp_nogap2", 64'(out_valid), 64'(1));
    tick(a);
    drain();

    // Streaming at full rate
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      C  = {$urandom, $urandom};
      D  = {$urandom, $urandom};
      Co = 1'($urandom_range(0, 1));
      if (i >= 2) chk("stream_valid", 64'(out_valid), 64'(1));
      tick(a);
      if (!a) chk("stream_acc", 64'(a), 64'(1));
    end
    drain();

    // Reset with two products in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    C = 64'h55; D = 64'h66;
    tick(a);
    C = 64'h77; D = 64'h88;
    tick(a);
    in_valid  = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_P", P, 64'(0));
    chk("mrst_ovf", 64'(ovf), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    hold_v = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(a);
      chk("mrst_stale", 64'(out_valid), 64'(0));
    end
    single(64'h3, 64'h4, 1'b0, 64'hA, 1'b0, "post_rst");

    // Random valid/ready; offered data is held until accepted
    pend = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        in_valid = 1'($urandom_range(0, 1));
        C  = {$urandom, $urandom};
        D  = {$urandom, $urandom};
        Co = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(a);
      pend = in_valid && !a;
    end
    drain();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
